// File: rtl/msrv32_dmem_bus_ctrl.sv
// Data-memory bus controller: turns store/load unit requests into single AHB-Lite transfers.
// Optional wait-state watchdog is compiled in with `define MSRV32_DMEM_TIMEOUT_EN.
module msrv32_dmem_bus_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        mem_wr_req_in,
    input  logic        mem_rd_req_in,
    input  logic [31:0] dmaddr_in,
    input  logic [31:0] dmdata_in,
    input  logic [3:0]  dmwr_mask_in,
    input  logic        ahb_hready_in,
    input  logic        ahb_hresp_in,
    input  logic [31:0] ahb_hrdata_in,
    output logic [31:0] ahb_haddr_out,
    output logic        ahb_hwrite_out,
    output logic [2:0]  ahb_hsize_out,
    output logic [1:0]  ahb_htrans_out,
    output logic [31:0] ahb_hwdata_out,
    output logic [3:0]  ahb_hwstrb_out,
    output logic        stall_out,
    output logic [31:0] rdata_out,
    output logic        done_out,
    output logic        err_out
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t      state_q;
    logic [31:0] haddr_q;
    logic        hwrite_q;
    logic [2:0]  hsize_q;
    logic [1:0]  htrans_q;
    logic [31:0] wdata_q;
    logic [31:0] hwdata_q;
    logic [3:0]  hwstrb_q;
    logic [31:0] rdata_q;
    logic        done_q;
    logic        err_q;

    logic        accept;
    logic [2:0]  size_d;
    logic [1:0]  off_d;
    logic        unused_addr_lsbs;

    assign unused_addr_lsbs = ^dmaddr_in[1:0];

`ifdef MSRV32_DMEM_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    logic [TIMEOUT_W-1:0] cnt_q;
    logic                 to_hit;
    assign to_hit = (cnt_q == TO_LAST);
`else
    localparam bit unused_timeout_cfg = (TIMEOUT_CYCLES < (2 ** TIMEOUT_W));
`endif

    // The done cycle blocks acceptance so a request still held high is seen one cycle later.
    assign accept    = (state_q == S_IDLE) & (mem_wr_req_in | mem_rd_req_in) &
                       (|dmwr_mask_in) & ~done_q & ~ms_riscv32_mp_rst_in;
    assign stall_out = (state_q != S_IDLE) | accept;

    // Transfer size and byte offset from the lane mask; irregular masks fall back to a word at offset 0.
    always_comb begin
        size_d = 3'b010;
        off_d  = 2'b00;
        case (dmwr_mask_in)
            4'b0011: size_d = 3'b001;
            4'b1100: begin size_d = 3'b001; off_d = 2'b10; end
            4'b0001: begin size_d = 3'b000; off_d = 2'b00; end
            4'b0010: begin size_d = 3'b000; off_d = 2'b01; end
            4'b0100: begin size_d = 3'b000; off_d = 2'b10; end
            4'b1000: begin size_d = 3'b000; off_d = 2'b11; end
            default: ;
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q  <= S_IDLE;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= '0;
            htrans_q <= '0;
            wdata_q  <= '0;
            hwdata_q <= '0;
            hwstrb_q <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef MSRV32_DMEM_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q  <= S_ADDR;
                        htrans_q <= 2'b10;
                        haddr_q  <= {dmaddr_in[31:2], off_d};
                        hsize_q  <= size_d;
                        hwrite_q <= mem_wr_req_in;
                        hwstrb_q <= dmwr_mask_in;
                        wdata_q  <= dmdata_in;
`ifdef MSRV32_DMEM_TIMEOUT_EN
                        cnt_q    <= '0;
`endif
                    end
                end
                S_ADDR: begin
                    if (ahb_hready_in) begin
                        state_q  <= S_DATA;
                        htrans_q <= 2'b00;
                        hwdata_q <= wdata_q;
                    end
`ifdef MSRV32_DMEM_TIMEOUT_EN
                    else if (to_hit) begin
                        state_q  <= S_IDLE;
                        htrans_q <= 2'b00;
                        done_q   <= 1'b1;
                        err_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                S_DATA: begin
                    // An error response leaves previously captured read data intact.
                    if (ahb_hready_in) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                        if (ahb_hresp_in) begin
                            err_q <= 1'b1;
                        end else if (!hwrite_q) begin
                            rdata_q <= ahb_hrdata_in;
                        end
                    end
`ifdef MSRV32_DMEM_TIMEOUT_EN
                    else if (to_hit) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ahb_haddr_out  = haddr_q;
    assign ahb_hwrite_out = hwrite_q;
    assign ahb_hsize_out  = hsize_q;
    assign ahb_htrans_out = htrans_q;
    assign ahb_hwdata_out = hwdata_q;
    assign ahb_hwstrb_out = hwstrb_q;
    assign rdata_out      = rdata_q;
    assign done_out       = done_q;
    assign err_out        = err_q;

endmodule

// File: tb/tb_msrv32_dmem_bus_ctrl.sv
// Bench for msrv32_dmem_bus_ctrl: vector table, hand-written corner sequences and random transfers.
module tb_msrv32_dmem_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req, rd_req;
    logic [31:0] dmaddr, dmdata;
    logic [3:0]  mask;
    logic        hready, hresp;
    logic [31:0] hrdata;
    logic [31:0] haddr, hwdata, rdata;
    logic        hwrite, stall, done, err;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [3:0]  hwstrb;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] model_rdata = 32'h0;

    msrv32_dmem_bus_ctrl #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(8)) dut (
        .ms_riscv32_mp_clk_in(clk),
        .ms_riscv32_mp_rst_in(rst),
        .mem_wr_req_in(wr_req),
        .mem_rd_req_in(rd_req),
        .dmaddr_in(dmaddr),
        .dmdata_in(dmdata),
        .dmwr_mask_in(mask),
        .ahb_hready_in(hready),
        .ahb_hresp_in(hresp),
        .ahb_hrdata_in(hrdata),
        .ahb_haddr_out(haddr),
        .ahb_hwrite_out(hwrite),
        .ahb_hsize_out(hsize),
        .ahb_htrans_out(htrans),
        .ahb_hwdata_out(hwdata),
        .ahb_hwstrb_out(hwstrb),
        .stall_out(stall),
        .rdata_out(rdata),
        .done_out(done),
        .err_out(err)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        int          wa;
        int          wd;
        bit          resp;
        logic [31:0] rdat;
        logic [31:0] exp_haddr;
        logic [2:0]  exp_hsize;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Reference: size/offset from the mask using bit counting rather than a lookup.
    function automatic logic [2:0] ref_size(input logic [3:0] m);
        if (m == 4'hF) return 3'b010;
        if (m == 4'b0011 || m == 4'b1100) return 3'b001;
        if ($countones(m) == 1) return 3'b000;
        return 3'b010;
    endfunction

    function automatic logic [1:0] ref_off(input logic [3:0] m);
        if (m == 4'b1100) return 2'd2;
        if ($countones(m) == 1) begin
            for (int b = 0; b < 4; b++) if (m[b]) return 2'(b);
        end
        return 2'd0;
    endfunction

    task automatic do_txn(input string tag, input bit wr, input bit rd, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] m, input int wa, input int wd,
                          input bit resp, input logic [31:0] rdat, input logic [31:0] exp_haddr,
                          input logic [2:0] exp_hsize);
        bit acc;
        acc = (wr | rd) && (m != 4'h0);
        next_cycle();
        wr_req = wr; rd_req = rd; dmaddr = addr; dmdata = data; mask = m;
        hready = 1'b1; hresp = 1'b0;
        #1;
        check({tag, ".stall_t0"}, stall, acc);
        check({tag, ".htrans_t0"}, htrans, 2'b00);
        next_cycle();
        wr_req = 1'b0; rd_req = 1'b0; dmaddr = ~addr; dmdata = ~data; mask = ~m;
        if (!acc) begin
            #1;
            check({tag, ".idle_htrans"}, htrans, 2'b00);
            check({tag, ".idle_done"}, done, 1'b0);
            check({tag, ".idle_stall"}, stall, 1'b0);
            return;
        end
        for (int i = 0; i <= wa; i++) begin
            hready = (i == wa);
            #1;
            check({tag, ".htrans_a"}, htrans, 2'b10);
            check({tag, ".haddr"}, haddr, exp_haddr);
            check({tag, ".hsize"}, hsize, exp_hsize);
            check({tag, ".hwrite"}, hwrite, wr);
            check({tag, ".hwstrb"}, hwstrb, m);
            check({tag, ".stall_a"}, stall, 1'b1);
            check({tag, ".done_a"}, done, 1'b0);
            next_cycle();
        end
        for (int i = 0; i <= wd; i++) begin
            hready = (i == wd);
            hresp  = (i == wd) && resp;
            hrdata = (i == wd) ? rdat : $urandom;
            #1;
            check({tag, ".htrans_d"}, htrans, 2'b00);
            check({tag, ".stall_d"}, stall, 1'b1);
            check({tag, ".done_d"}, done, 1'b0);
            if (wr) check({tag, ".hwdata"}, hwdata, data);
            next_cycle();
        end
        hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
        if (!wr && !resp) model_rdata = rdat;
        #1;
        check({tag, ".done"}, done, 1'b1);
        check({tag, ".err"}, err, resp);
        check({tag, ".stall_done"}, stall, 1'b0);
        check({tag, ".rdata"}, rdata, model_rdata);
        next_cycle();
        #1;
        check({tag, ".done_pulse"}, done, 1'b0);
    endtask

    initial begin
        bit saw_done;
        tbl[0] = '{1, 0, 32'h100, 32'hDEADBEEF, 4'b1111, 0, 0, 0, 32'h0,        32'h100, 3'b010};
        tbl[1] = '{1, 0, 32'h204, 32'h00AB0000, 4'b0100, 0, 0, 0, 32'h0,        32'h206, 3'b000};
        tbl[2] = '{0, 1, 32'h300, 32'h0,        4'b1111, 0, 3, 0, 32'h12345678, 32'h300, 3'b010};
        tbl[3] = '{0, 1, 32'h400, 32'h0,        4'b1111, 0, 1, 1, 32'hFFFF0000, 32'h400, 3'b010};
        tbl[4] = '{1, 0, 32'h500, 32'h55660000, 4'b1100, 2, 0, 0, 32'h0,        32'h502, 3'b001};
        tbl[5] = '{0, 1, 32'h600, 32'h0,        4'b0011, 1, 1, 0, 32'hCAFE0001, 32'h600, 3'b001};
        tbl[6] = '{1, 1, 32'h704, 32'h77000000, 4'b1000, 0, 0, 0, 32'h11111111, 32'h707, 3'b000};
        tbl[7] = '{0, 1, 32'h800, 32'h0,        4'b0110, 1, 2, 0, 32'hA5A5A5A5, 32'h800, 3'b010};
        tbl[8] = '{1, 0, 32'h900, 32'h000000EE, 4'b0001, 0, 1, 1, 32'h0,        32'h900, 3'b000};
        tbl[9] = '{1, 0, 32'hA00, 32'h12121212, 4'b0000, 0, 0, 0, 32'h0,        32'h0,   3'b000};

        rst = 1'b1; wr_req = 0; rd_req = 0; dmaddr = 0; dmdata = 0; mask = 0;
        hready = 1'b1; hresp = 1'b0; hrdata = 0;
        #12;
        check("rst.htrans", htrans, 2'b00);
        check("rst.haddr", haddr, 32'h0);
        check("rst.hsize", hsize, 3'b000);
        check("rst.hwrite", hwrite, 1'b0);
        check("rst.hwdata", hwdata, 32'h0);
        check("rst.hwstrb", hwstrb, 4'h0);
        check("rst.stall", stall, 1'b0);
        check("rst.rdata", rdata, 32'h0);
        check("rst.done", done, 1'b0);
        check("rst.err", err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            do_txn($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data,
                   tbl[i].mask, tbl[i].wa, tbl[i].wd, tbl[i].resp, tbl[i].rdat,
                   tbl[i].exp_haddr, tbl[i].exp_hsize);

        // Request held through the done cycle is only taken on the following cycle.
        next_cycle();
        wr_req = 1'b1; dmaddr = 32'hB00; dmdata = 32'h0F0F0F0F; mask = 4'hF; hready = 1'b1;
        #1; check("hold.stall_t0", stall, 1'b1);
        next_cycle(); #1; check("hold.htrans_t1", htrans, 2'b10);
        next_cycle(); #1; check("hold.htrans_t2", htrans, 2'b00);
        next_cycle(); #1;
        check("hold.done_t3", done, 1'b1);
        check("hold.stall_t3", stall, 1'b0);
        next_cycle(); #1;
        check("hold.htrans_t4", htrans, 2'b00);
        check("hold.stall_t4", stall, 1'b1);
        next_cycle(); wr_req = 1'b0; #1;
        check("hold.htrans_t5", htrans, 2'b10);
        next_cycle(); next_cycle(); #1;
        check("hold.done_t7", done, 1'b1);

        // Asynchronous reset while the address phase is on the bus.
        next_cycle();
        rd_req = 1'b1; dmaddr = 32'hC00; mask = 4'hF; hready = 1'b0;
        next_cycle();
        rd_req = 1'b0;
        #1; check("rstmid.htrans_before", htrans, 2'b10);
        rst = 1'b1;
        #1;
        check("rstmid.htrans", htrans, 2'b00);
        check("rstmid.stall", stall, 1'b0);
        check("rstmid.rdata", rdata, 32'h0);
        model_rdata = 32'h0;
        next_cycle();
        rst = 1'b0; hready = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; if (done) saw_done = 1'b1;
            next_cycle();
        end
        check("rstmid.no_done", saw_done, 1'b0);
        check("rstmid.idle_htrans", htrans, 2'b00);

        // Slave never asserts hready.
        next_cycle();
        rd_req = 1'b1; dmaddr = 32'hD00; mask = 4'hF; hready = 1'b0;
        next_cycle();
        rd_req = 1'b0;
`ifdef MSRV32_DMEM_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            #1;
            check("to.done_wait", done, 1'b0);
            check("to.stall_wait", stall, 1'b1);
            next_cycle();
        end
        #1;
        check("to.done", done, 1'b1);
        check("to.err", err, 1'b1);
        check("to.htrans", htrans, 2'b00);
        check("to.stall", stall, 1'b0);
        check("to.rdata", rdata, model_rdata);
        hready = 1'b1;
`else
        saw_done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1; if (done) saw_done = 1'b1;
            next_cycle();
        end
        #1;
        check("noto.stall", stall, 1'b1);
        check("noto.no_done", saw_done, 1'b0);
        check("noto.htrans", htrans, 2'b10);
        hready = 1'b1;
        next_cycle();
        hrdata = 32'h0BADF00D;
        next_cycle();
        model_rdata = 32'h0BADF00D;
        #1;
        check("noto.done", done, 1'b1);
        check("noto.err", err, 1'b0);
        check("noto.rdata", rdata, model_rdata);
`endif

        for (int n = 0; n < 40; n++) begin
            bit          w, r, rs;
            logic [3:0]  m;
            logic [31:0] a;
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            if (!w && !r && $urandom_range(0, 3) != 0) r = 1'b1;
            case ($urandom_range(0, 3))
                0: m = 4'hF;
                1: m = ($urandom_range(0, 1) != 0) ? 4'b0011 : 4'b1100;
                2: m = 4'(1 << $urandom_range(0, 3));
                default: m = 4'($urandom);
            endcase
            a  = {$urandom, 2'b00};
            a  = {a[31:2], 2'b00};
            rs = ($urandom_range(0, 7) == 0);
            do_txn($sformatf("rnd%0d", n), w, r, a, $urandom, m, $urandom_range(0, 2),
                   $urandom_range(0, 3), rs, $urandom, {a[31:2], ref_off(m)}, ref_size(m));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
